sx_pkt_arbiter: RTL and testbench

Packet-level round-robin arbiter for the S_DATA_COUNT:1 AXI-Stream mux (sx_mux).
- Grants exactly one slave port at a time.
- Holds the grant until that port's packet completes (last beat accepted on the mux output).
- Drives the mux select (one-hot plus binary id).
- Sits beside sx_mux inside the switch; sx_mux steers data, keep, last and ready using grant_o.

---
 rtl/sx_pkg.sv | 34 +++
 rtl/sx_rr_pick.sv | 24 ++
 rtl/sx_pkt_arbiter.sv | 138 +++++++++++++
 tb/tb_sx_pkt_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sx_pkg.sv
// rtl/sx_pkg.sv - shared types and rotating-priority pick helper for the sx switch
package sx_pkg;

  typedef enum logic {IDLE, BUSY} arb_state_t;

  localparam int WDT_CYCLES_DEF = 1024;
  localparam int RR_MAX         = 64;

  typedef struct packed {
    logic       found;
    logic [7:0] idx;
  } rr_pick_t;

  // First set bit of req[n-1:0] searching from ptr+1 upward with wrap-around.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] req,
                                       input int unsigned n,
                                       input int unsigned ptr);
    rr_pick_t    r;
    int unsigned k;
    r = '0;
    for (int unsigned i = 1; i <= RR_MAX; i++) begin
      if (i <= n) begin
        k = ptr + i;
        if (k >= n) k = k - n;
        if (!r.found && req[k[5:0]]) begin
          r.found = 1'b1;
          r.idx   = k[7:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sx_rr_pick.sv
// rtl/sx_rr_pick.sv - combinational rotating-priority encoder (req, ptr -> idx, found)
module sx_rr_pick
  import sx_pkg::*;
#(
  parameter int N  = 10,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);

  rr_pick_t          pick;
  logic [RR_MAX-1:0] req_ext;

  always_comb begin
    req_ext = RR_MAX'(req_i);
    pick    = rr_pick(req_ext, N, 32'(ptr_i));
    idx_o   = IW'(pick.idx);
    found_o = pick.found;
  end

endmodule

// File: rtl/sx_pkt_arbiter.sv
// rtl/sx_pkt_arbiter.sv - packet-level round-robin arbiter driving the sx_mux select
// Optional stall watchdog enabled by defining SX_ARB_WDT_EN.
module sx_pkt_arbiter
  import sx_pkg::*;
#(
  parameter int S_DATA_COUNT = 10,
  parameter int ID_WIDTH     = $clog2(S_DATA_COUNT),
  parameter int WDT_CYCLES   = WDT_CYCLES_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [S_DATA_COUNT-1:0] s_valid_i,
  input  logic                    m_valid_i,
  input  logic                    m_ready_i,
  input  logic                    m_last_i,
  output logic [S_DATA_COUNT-1:0] grant_o,
  output logic [ID_WIDTH-1:0]     grant_id_o,
  output logic                    grant_valid_o,
  output logic                    wdt_flag_o
);

  if (S_DATA_COUNT < 2 || WDT_CYCLES < 2) begin : g_bad_cfg
    $error("sx_pkt_arbiter: S_DATA_COUNT and WDT_CYCLES must be >= 2");
  end

  localparam logic [ID_WIDTH-1:0] PTR_RST = ID_WIDTH'(S_DATA_COUNT - 1);

  arb_state_t              state_q, state_d;
  logic [ID_WIDTH-1:0]     ptr_q, ptr_d;
  logic [ID_WIDTH-1:0]     grant_id_q, grant_id_d;
  logic [S_DATA_COUNT-1:0] grant_q, grant_d;
  logic                    grant_valid_q, grant_valid_d;
  logic                    wdt_flag_q, wdt_flag_d;

  logic                    beat, eop, rel, wdt_fire;
  logic                    pick_found;
  logic [ID_WIDTH-1:0]     pick_idx;
  logic [S_DATA_COUNT-1:0] req_x, pick_onehot;

  assign beat = m_valid_i & m_ready_i;
  assign eop  = beat & m_last_i;

  // The holder is masked so a released grant rotates; in IDLE grant_q is zero.
  assign req_x       = s_valid_i & ~grant_q;
  assign pick_onehot = S_DATA_COUNT'(1) << pick_idx;

  sx_rr_pick #(.N(S_DATA_COUNT), .IW(ID_WIDTH)) u_pick (
    .req_i   (req_x),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

`ifdef SX_ARB_WDT_EN
  localparam int CW = $clog2(WDT_CYCLES);

  logic [CW-1:0] wdt_cnt_q, wdt_cnt_d;

  assign wdt_fire = (state_q == BUSY) && !beat && (wdt_cnt_q == CW'(WDT_CYCLES - 1));

  always_comb begin
    wdt_cnt_d = '0;
    if (state_q == BUSY && !beat && !rel) wdt_cnt_d = wdt_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wdt_cnt_q <= '0;
    else       wdt_cnt_q <= wdt_cnt_d;
  end
`else
  assign wdt_fire = 1'b0;
`endif

  assign rel = (state_q == BUSY) && (eop || wdt_fire);

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_d       = grant_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    wdt_flag_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d       = BUSY;
          ptr_d         = pick_idx;
          grant_d       = pick_onehot;
          grant_id_d    = pick_idx;
          grant_valid_d = 1'b1;
        end
      end
      BUSY: begin
        if (rel) begin
          wdt_flag_d = wdt_fire;
          if (pick_found) begin
            ptr_d      = pick_idx;
            grant_d    = pick_onehot;
            grant_id_d = pick_idx;
          end else if (!(|(s_valid_i & grant_q))) begin
            state_d       = IDLE;
            grant_d       = '0;
            grant_id_d    = '0;
            grant_valid_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      ptr_q         <= PTR_RST;
      grant_q       <= '0;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      wdt_flag_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_q       <= grant_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      wdt_flag_q    <= wdt_flag_d;
    end
  end

  assign grant_o       = grant_q;
  assign grant_id_o    = grant_id_q;
  assign grant_valid_o = grant_valid_q;
  assign wdt_flag_o    = wdt_flag_q;

  a_no_eop_in_idle: assert property (@(posedge clk) disable iff (reset)
    !(state_q == IDLE && eop));

endmodule

// File: tb/tb_sx_pkt_arbiter.sv
// tb/tb_sx_pkt_arbiter.sv - scoreboard bench for sx_pkt_arbiter against a packet-level model
module tb_sx_pkt_arbiter;

  localparam int N  = 10;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  s_valid_i = '0;
  logic          m_valid_i = 1'b0;
  logic          m_ready_i = 1'b0;
  logic          m_last_i = 1'b0;
  logic [N-1:0]  grant_o;
  logic [IW-1:0] grant_id_o;
  logic          grant_valid_o;
  logic          wdt_flag_o;

  sx_pkt_arbiter #(.S_DATA_COUNT(N), .ID_WIDTH(IW)) dut (
    .clk           (clk),
    .reset         (reset),
    .s_valid_i     (s_valid_i),
    .m_valid_i     (m_valid_i),
    .m_ready_i     (m_ready_i),
    .m_last_i      (m_last_i),
    .grant_o       (grant_o),
    .grant_id_o    (grant_id_o),
    .grant_valid_o (grant_valid_o),
    .wdt_flag_o    (wdt_flag_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          gv;
    logic [IW-1:0] id;
    logic [N-1:0]  gnt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  // Reference model: who holds the mux, where the rotation last stopped, beats left in the packet.
  bit   m_busy = 0;
  int   m_holder = 0;
  int   m_ptr = N - 1;
  int   m_left = 0;
  int   plen[N];
  bit   rand_len = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int search(input logic [N-1:0] r, input int from);
    for (int i = 1; i <= N; i++) begin
      int p;
      p = (from + i) % N;
      if (r[p]) return p;
    end
    return -1;
  endfunction

  function automatic int new_len(input int port);
    if (rand_len) return int'($urandom_range(1, 4));
    return plen[port];
  endfunction

  // One clock of stimulus: drive at the falling edge, advance the model, queue the expected grant.
  task automatic cyc(input logic [N-1:0] sv, input logic mv, input logic rdy);
    logic         mvv, lst, beat, eop;
    logic [N-1:0] others;
    exp_t         e;
    @(negedge clk);
    mvv  = m_busy && mv;
    beat = mvv && rdy;
    lst  = beat ? (m_left == 1) : logic'($urandom_range(0, 1));
    eop  = beat && lst;
    s_valid_i = sv;
    m_valid_i = mvv;
    m_ready_i = rdy;
    m_last_i  = lst;
    if (beat) m_left--;
    if (!m_busy) begin
      if (sv != '0) begin
        m_holder = search(sv, m_ptr);
        m_ptr    = m_holder;
        m_busy   = 1;
        m_left   = new_len(m_holder);
      end
    end else if (eop) begin
      others = sv;
      others[m_holder] = 1'b0;
      if (others != '0) begin
        m_holder = search(others, m_ptr);
        m_ptr    = m_holder;
        m_left   = new_len(m_holder);
      end else if (sv[m_holder]) begin
        m_left = new_len(m_holder);
      end else begin
        m_busy = 0;
      end
    end
    e.gv  = m_busy;
    e.id  = m_busy ? IW'(m_holder) : '0;
    e.gnt = m_busy ? (N'(1) << m_holder) : '0;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && m_busy; k++) cyc('0, 1'b1, 1'b1);
    cyc('0, 1'b0, 1'b1);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("grant_valid", 32'(grant_valid_o), 32'(e.gv));
        check("grant_id", 32'(grant_id_o), 32'(e.id));
        check("grant", 32'(grant_o), 32'(e.gnt));
        check("wdt_flag", 32'(wdt_flag_o), 32'h0);
      end
    end
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL timeout: got running expected finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    for (int p = 0; p < N; p++) plen[p] = 2;
    repeat (2) @(negedge clk);
    check("rst_grant", 32'(grant_o), 32'h0);
    check("rst_grant_id", 32'(grant_id_o), 32'h0);
    check("rst_grant_valid", 32'(grant_valid_o), 32'h0);
    check("rst_wdt_flag", 32'(wdt_flag_o), 32'h0);
    reset = 1'b0;
    cyc('0, 1'b0, 1'b1);
    cyc('0, 1'b0, 1'b1);

    // Port 2 alone, 3-beat packet, request dropped on the last beat.
    plen[2] = 3;
    cyc(10'h004, 1'b0, 1'b1);
    cyc(10'h004, 1'b1, 1'b1);
    cyc(10'h004, 1'b1, 1'b1);
    cyc(10'h000, 1'b1, 1'b1);
    cyc(10'h000, 1'b0, 1'b1);

    // All ports requesting, 2-beat packets: strict rotation with no gaps.
    for (int p = 0; p < N; p++) plen[p] = 2;
    for (int k = 0; k < 23; k++) cyc(10'h3FF, 1'b1, 1'b1);
    drain();

    // Port 4 stalls mid-packet while port 5 waits.
    plen[4] = 3;
    plen[5] = 2;
    cyc(10'h010, 1'b0, 1'b1);
    cyc(10'h030, 1'b1, 1'b1);
    for (int k = 0; k < 50; k++) cyc(10'h030, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) cyc(10'h020, 1'b1, 1'b1);
    drain();

    // Single-beat packets from ports 1 and 7, then port 1 alone.
    plen[1] = 1;
    plen[7] = 1;
    for (int k = 0; k < 12; k++) cyc(10'h082, 1'b1, 1'b1);
    for (int k = 0; k < 6; k++) cyc(10'h002, 1'b1, 1'b1);
    drain();

    // Reset during port 6's second beat.
    plen[6] = 3;
    cyc(10'h040, 1'b0, 1'b1);
    cyc(10'h040, 1'b1, 1'b1);
    @(negedge clk);
    s_valid_i = 10'h040;
    m_valid_i = 1'b1;
    m_ready_i = 1'b1;
    m_last_i  = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_grant", 32'(grant_o), 32'h0);
    check("async_rst_grant_id", 32'(grant_id_o), 32'h0);
    check("async_rst_grant_valid", 32'(grant_valid_o), 32'h0);
    @(negedge clk);
    s_valid_i = '0;
    m_valid_i = 1'b0;
    reset     = 1'b0;
    m_busy    = 0;
    m_ptr     = N - 1;
    plen[6]   = 2;
    plen[7]   = 2;
    cyc(10'h0C0, 1'b0, 1'b1);
    cyc(10'h0C0, 1'b1, 1'b1);
    cyc(10'h0C0, 1'b1, 1'b1);
    drain();

    // Randomised traffic with random packet lengths, valid gaps and backpressure.
    rand_len = 1;
    for (int k = 0; k < 500; k++) begin
      logic [N-1:0] sv;
      sv = N'($urandom);
      if ($urandom_range(0, 4) == 0) sv = '0;
      cyc(sv, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end
    drain();

    repeat (3) @(posedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
